// File: rtl/reservation_station_age_ordered.sv
// Reservation station with age-ordered issue, multi-CDB wakeup and
// branch-mask based selective squash.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_iq_*                        dispatch from instruction queue (valid/ready,
//                                 source tags/values, dest tag, branch mask)
//   i_branch_valid/id/correct     branch resolution (clear bit or squash)
//   i_cdb_valid/tag/data_flatten  NUM_CDB result buses snooped every cycle
//   o_exe_*                       issue of the oldest ready entry (valid/ready,
//                                 dest tag, operand values, live branch mask)
//   o_occupancy                   registered count of valid entries
module reservation_station_age_ordered #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4,
  parameter int NUM_OPERAND       = 2,
  parameter int NUM_ENTRY         = 8,
  parameter int NUM_CDB           = 2,
  parameter int NUM_BRANCH        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_iq_valid,
  output logic                                       i_iq_ready,
  input  logic [NUM_OPERAND*BW_TAG-1:0]              i_iq_Q_flatten,
  input  logic [NUM_OPERAND*BW_PROCESSOR_DATA-1:0]   i_iq_V_flatten,
  input  logic [BW_TAG-1:0]                          i_iq_tag,
  input  logic [NUM_BRANCH-1:0]                      i_iq_branch_mask,
  input  logic                                       i_branch_valid,
  input  logic [$clog2(NUM_BRANCH)-1:0]              i_branch_id,
  input  logic                                       i_branch_correct,
  input  logic [NUM_CDB-1:0]                         i_cdb_valid,
  input  logic [NUM_CDB*BW_TAG-1:0]                  i_cdb_tag_flatten,
  input  logic [NUM_CDB*BW_PROCESSOR_DATA-1:0]       i_cdb_data_flatten,
  output logic                                       o_exe_valid,
  input  logic                                       o_exe_ready,
  output logic [BW_TAG-1:0]                          o_exe_tag,
  output logic [NUM_OPERAND*BW_PROCESSOR_DATA-1:0]   o_exe_V_flatten,
  output logic [NUM_BRANCH-1:0]                      o_exe_branch_mask,
  output logic [$clog2(NUM_ENTRY+1)-1:0]             o_occupancy
);

  localparam int BW_OCC = $clog2(NUM_ENTRY + 1);

  typedef logic [NUM_OPERAND-1:0][BW_TAG-1:0]            q_t;
  typedef logic [NUM_OPERAND-1:0][BW_PROCESSOR_DATA-1:0] v_t;

  // Registered entry state; age_r[i][j] = 1 means entry i is older than j.
  logic [NUM_ENTRY-1:0]  valid_r;
  q_t                    q_r    [NUM_ENTRY];
  v_t                    v_r    [NUM_ENTRY];
  logic [BW_TAG-1:0]     tag_r  [NUM_ENTRY];
  logic [NUM_BRANCH-1:0] mask_r [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]  age_r  [NUM_ENTRY];
  logic [BW_OCC-1:0]     occ_r;

  logic [NUM_ENTRY-1:0]  valid_nxt;
  q_t                    q_nxt    [NUM_ENTRY];
  v_t                    v_nxt    [NUM_ENTRY];
  logic [BW_TAG-1:0]     tag_nxt  [NUM_ENTRY];
  logic [NUM_BRANCH-1:0] mask_nxt [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]  age_nxt  [NUM_ENTRY];
  logic [BW_OCC-1:0]     occ_nxt;

  logic                  mispredict;
  logic [NUM_BRANCH-1:0] clr_mask;
  logic [NUM_ENTRY-1:0]  squash, rdy, sel, avail, slot_oh;
  logic                  hs, load_en;
  q_t                    new_q;
  v_t                    new_v;
  v_t                    exe_v;

  // First (lowest-index) valid bus carrying a non-zero matching tag.
  function automatic void cdb_lookup(input  logic [BW_TAG-1:0]            q,
                                     output logic                         hit,
                                     output logic [BW_PROCESSOR_DATA-1:0] data);
    hit  = 1'b0;
    data = '0;
    for (int unsigned b = 0; b < NUM_CDB; b++) begin
      if (!hit && q != '0 && i_cdb_valid[b] &&
          i_cdb_tag_flatten[b*BW_TAG +: BW_TAG] == q) begin
        hit  = 1'b1;
        data = i_cdb_data_flatten[b*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
      end
    end
  endfunction

  // Readiness from registered state only; entries squashed this cycle drop out
  // so the age search naturally falls through to the next-oldest one.
  always_comb begin
    mispredict = i_branch_valid && !i_branch_correct;
    clr_mask   = '0;
    if (i_branch_valid && i_branch_correct) clr_mask[i_branch_id] = 1'b1;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      squash[i] = valid_r[i] && mispredict && mask_r[i][i_branch_id];
      rdy[i]    = valid_r[i] && !squash[i] && (q_r[i] == '0);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      sel[i] = rdy[i];
      for (int unsigned j = 0; j < NUM_ENTRY; j++) begin
        if (j != i && rdy[j] && age_r[j][i]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    o_exe_tag         = '0;
    exe_v             = '0;
    o_exe_branch_mask = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      if (sel[i]) begin
        o_exe_tag         = o_exe_tag | tag_r[i];
        exe_v             = exe_v | v_r[i];
        o_exe_branch_mask = o_exe_branch_mask | (mask_r[i] & ~clr_mask);
      end
    end
    o_exe_valid = |rdy;
    hs          = o_exe_valid && o_exe_ready;
    avail       = ~valid_r | (hs ? sel : '0);
    i_iq_ready  = |avail;
    slot_oh     = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      if (avail[i] && slot_oh == '0) slot_oh[i] = 1'b1;
    end
    // A dispatching op on the mispredicted path completes the handshake but is dropped.
    load_en = i_iq_valid && i_iq_ready && !(mispredict && i_iq_branch_mask[i_branch_id]);
  end

  assign o_exe_V_flatten = exe_v;
  assign o_occupancy     = occ_r;

  always_comb begin
    logic                         hit;
    logic [BW_PROCESSOR_DATA-1:0] data;
    for (int unsigned k = 0; k < NUM_OPERAND; k++) begin
      cdb_lookup(i_iq_Q_flatten[k*BW_TAG +: BW_TAG], hit, data);
      new_q[k] = hit ? '0 : i_iq_Q_flatten[k*BW_TAG +: BW_TAG];
      new_v[k] = hit ? data : i_iq_V_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
    end
    occ_nxt = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      valid_nxt[i] = (valid_r[i] && !squash[i] && !(hs && sel[i])) || (load_en && slot_oh[i]);
      tag_nxt[i]   = tag_r[i];
      mask_nxt[i]  = mask_r[i] & ~clr_mask;
      for (int unsigned k = 0; k < NUM_OPERAND; k++) begin
        cdb_lookup(q_r[i][k], hit, data);
        q_nxt[i][k] = hit ? '0 : q_r[i][k];
        v_nxt[i][k] = hit ? data : v_r[i][k];
      end
      age_nxt[i] = age_r[i];
      if (load_en) begin
        // New entry is younger than everyone: clear its row, set its column.
        age_nxt[i] = slot_oh[i] ? '0 : (age_r[i] | slot_oh);
        if (slot_oh[i]) begin
          q_nxt[i]    = new_q;
          v_nxt[i]    = new_v;
          tag_nxt[i]  = i_iq_tag;
          mask_nxt[i] = i_iq_branch_mask & ~clr_mask;
        end
      end
      occ_nxt = occ_nxt + BW_OCC'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      occ_r   <= '0;
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        q_r[i]    <= '0;
        v_r[i]    <= '0;
        tag_r[i]  <= '0;
        mask_r[i] <= '0;
        age_r[i]  <= '0;
      end
    end else begin
      valid_r <= valid_nxt;
      occ_r   <= occ_nxt;
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        q_r[i]    <= q_nxt[i];
        v_r[i]    <= v_nxt[i];
        tag_r[i]  <= tag_nxt[i];
        mask_r[i] <= mask_nxt[i];
        age_r[i]  <= age_nxt[i];
      end
    end
  end

endmodule
